// File: rtl/acq_sequencer_if.sv
// Acquisition sequencer bus: SPI command, trigger config, front-end and readout handshake.
// master drives commands/config; slave is the sequencer itself.
interface acq_sequencer_if;
  logic [1:0]  instruction;
  logic [1:0]  mode;
  logic [7:0]  trigger_channel_mask;
  logic [7:0]  disc_polarity;
  logic [7:0]  disc_in;
  logic [5:0]  trigger_delay;
  logic        slow_mode;
  logic        pll_switch;
  logic        pll_locked;
  logic        readout_done;
  logic        sample_en;
  logic        trig_out;
  logic        readout_start;
  logic        busy;
  logic [1:0]  state;
  logic [7:0]  hit_mask;
  logic [15:0] event_count;
  logic        pll_err;

  modport master (
    output instruction, mode, trigger_channel_mask,
    output disc_polarity, disc_in, trigger_delay,
    output slow_mode, pll_switch, pll_locked,
    output readout_done,
    input  sample_en, trig_out, readout_start, busy,
    input  state, hit_mask, event_count, pll_err
  );

  modport slave (
    input  instruction, mode, trigger_channel_mask,
    input  disc_polarity, disc_in, trigger_delay,
    input  slow_mode, pll_switch, pll_locked,
    input  readout_done,
    output sample_en, trig_out, readout_start, busy,
    output state, hit_mask, event_count, pll_err
  );
endinterface

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms on START, triggers on discriminator hit
// or SOFT_TRIG, waits a programmable delay, then hands off to readout.
module acq_sequencer (
  input  logic clk,
  input  logic rst,
  acq_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_DELAY   = 2'b10,
    S_READOUT = 2'b11
  } state_t;

  localparam logic [1:0] I_START = 2'd1;
  localparam logic [1:0] I_SOFT  = 2'd2;
  localparam logic [1:0] I_STOP  = 2'd3;

  state_t      state_q;
  state_t      state_n;
  logic [1:0]  ins_s1;
  logic [1:0]  ins_s2;
  logic [1:0]  ins_prev;
  logic [7:0]  dly_cnt;
  logic        stop_pend;
  logic        sample_en_q;
  logic        trig_q;
  logic        rs_q;
  logic        busy_q;
  logic [7:0]  hit_mask_q;
  logic [15:0] evt_q;
  logic        pll_err_q;

  logic        cmd_vld;
  logic        is_start;
  logic        is_soft;
  logic        is_stop;
  logic [7:0]  hit_vec;
  logic        hit;
  logic        pll_bad;
  logic [7:0]  dly_load;

  logic        trig_n;
  logic        rs_n;
  logic        done_ev;
  logic        start_ok;
  logic        start_bad;

  // A command fires once, on the cycle the synced code first changes.
  assign cmd_vld  = (ins_s2 != ins_prev) && (ins_s2 != 2'd0);
  assign is_start = cmd_vld && (ins_s2 == I_START);
  assign is_soft  = cmd_vld && (ins_s2 == I_SOFT);
  assign is_stop  = cmd_vld && (ins_s2 == I_STOP);

  assign hit_vec = (bus.disc_in ^ bus.disc_polarity)
                 & bus.trigger_channel_mask
                 & {8{~bus.mode[1]}};
  assign hit     = |hit_vec;
  assign pll_bad = bus.pll_switch && !bus.pll_locked;

  // Counter holds cycles-minus-one; slow ticks are 4 clocks each.
  assign dly_load = bus.slow_mode ? {bus.trigger_delay, 2'b11}
                                  : {2'b00, bus.trigger_delay};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_start && !pll_bad) state_n = S_ARMED;
      end
      S_ARMED: begin
        if (is_stop)                state_n = S_IDLE;
        else if (hit || is_soft)    state_n = S_DELAY;
      end
      S_DELAY: begin
        if (is_stop)                state_n = S_IDLE;
        else if (dly_cnt == 8'd0)   state_n = S_READOUT;
      end
      S_READOUT: begin
        if (bus.readout_done) begin
          if (bus.mode == 2'd1 && !stop_pend && !is_stop)
            state_n = S_ARMED;
          else
            state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    trig_n    = 1'b0;
    rs_n      = 1'b0;
    done_ev   = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_ok  = is_start && !pll_bad;
        start_bad = is_start && pll_bad;
      end
      S_ARMED:   trig_n  = (state_n == S_DELAY);
      S_DELAY:   rs_n    = (state_n == S_READOUT);
      S_READOUT: done_ev = bus.readout_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_s1      <= 2'd0;
      ins_s2      <= 2'd0;
      ins_prev    <= 2'd0;
      dly_cnt     <= 8'd0;
      stop_pend   <= 1'b0;
      sample_en_q <= 1'b0;
      trig_q      <= 1'b0;
      rs_q        <= 1'b0;
      busy_q      <= 1'b0;
      hit_mask_q  <= 8'h00;
      evt_q       <= 16'h0000;
      pll_err_q   <= 1'b0;
    end else begin
      ins_s1      <= bus.instruction;
      ins_s2      <= ins_s1;
      ins_prev    <= ins_s2;
      sample_en_q <= (state_n == S_ARMED) || (state_n == S_DELAY);
      busy_q      <= (state_n != S_IDLE);
      trig_q      <= trig_n;
      rs_q        <= rs_n;
      if (trig_n) begin
        hit_mask_q <= hit_vec;
        dly_cnt    <= dly_load;
      end else if (state_q == S_DELAY && dly_cnt != 8'd0) begin
        dly_cnt    <= dly_cnt - 8'd1;
      end
      if (state_n != S_READOUT)
        stop_pend <= 1'b0;
      else if (state_q == S_READOUT && is_stop)
        stop_pend <= 1'b1;
      if (done_ev && evt_q != 16'hFFFF)
        evt_q <= evt_q + 16'd1;
      if (start_bad)
        pll_err_q <= 1'b1;
      else if (start_ok)
        pll_err_q <= 1'b0;
    end
  end

  assign bus.state         = state_q;
  assign bus.sample_en     = sample_en_q;
  assign bus.trig_out      = trig_q;
  assign bus.readout_start = rs_q;
  assign bus.busy          = busy_q;
  assign bus.hit_mask      = hit_mask_q;
  assign bus.event_count   = evt_q;
  assign bus.pll_err       = pll_err_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: directed scenarios plus randomized
// triggers checked against an arithmetic reference model.
module tb_acq_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  acq_sequencer_if bus ();

  acq_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ARMED = 2'b01;
  localparam logic [1:0] DELAY = 2'b10;
  localparam logic [1:0] READOUT = 2'b11;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_on(input logic [1:0] c);
    bus.instruction = c;
    repeat (3) tick();
  endtask

  task automatic cmd_off();
    bus.instruction = 2'd0;
    repeat (3) tick();
  endtask

  task automatic setup(input logic [1:0] m, input logic [7:0] msk,
                       input logic [7:0] pol, input logic [5:0] td,
                       input logic sl);
    bus.mode = m;
    bus.trigger_channel_mask = msk;
    bus.disc_polarity = pol;
    bus.disc_in = pol;
    bus.trigger_delay = td;
    bus.slow_mode = sl;
  endtask

  task automatic wait_trig(input string nm);
    int i;
    for (i = 0; i < 50; i++) begin
      tick();
      if (bus.trig_out === 1'b1) break;
    end
    checks++;
    if (i >= 50) begin
      errors++;
      $display("FAIL %s trig timeout: got no trig_out, need pulse", nm);
    end
  endtask

  // Expected delay length, mask and next state come from the caller's model.
  task automatic run_event(input string nm, input logic [7:0] emask,
                           input int elen, input logic [1:0] enext,
                           input bit stop_mid);
    int n;
    int tc;
    checks++;
    if (bus.hit_mask !== emask || bus.state !== DELAY
        || bus.sample_en !== 1'b1) begin
      errors++;
      $display("FAIL %s trig: mask=%h st=%0d se=%b, need %h/2/1",
               nm, bus.hit_mask, bus.state, bus.sample_en, emask);
    end
    n = 0;
    tc = 0;
    while (bus.state === DELAY && n < 400) begin
      if (bus.trig_out === 1'b1) tc++;
      n++;
      tick();
    end
    checks++;
    if (n != elen || tc != 1) begin
      errors++;
      $display("FAIL %s delay: cycles=%0d trig=%0d, need %0d/1",
               nm, n, tc, elen);
    end
    checks++;
    if (bus.state !== READOUT || bus.readout_start !== 1'b1
        || bus.sample_en !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s ro_entry: st=%0d rs=%b se=%b bz=%b, need 3/1/0/1",
               nm, bus.state, bus.readout_start, bus.sample_en, bus.busy);
    end
    tick();
    checks++;
    if (bus.readout_start !== 1'b0 || bus.state !== READOUT) begin
      errors++;
      $display("FAIL %s rs_pulse: rs=%b st=%0d, need 0/3",
               nm, bus.readout_start, bus.state);
    end
    if (stop_mid) begin
      cmd_on(2'd3);
      cmd_off();
      checks++;
      if (bus.state !== READOUT) begin
        errors++;
        $display("FAIL %s stop_hold: st=%0d, need 3", nm, bus.state);
      end
    end
    repeat ($urandom_range(0, 3)) tick();
    bus.readout_done = 1'b1;
    tick();
    bus.readout_done = 1'b0;
    if (exp_count < 65535) exp_count++;
    checks++;
    if (bus.state !== enext || bus.event_count !== 16'(exp_count)
        || bus.busy !== (enext != IDLE)
        || bus.sample_en !== (enext == ARMED)) begin
      errors++;
      $display("FAIL %s done: st=%0d cnt=%0d bz=%b se=%b, need %0d/%0d",
               nm, bus.state, bus.event_count, bus.busy, bus.sample_en,
               enext, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    exp_count = 0;
    checks++;
    if (bus.state !== IDLE || bus.sample_en !== 1'b0
        || bus.trig_out !== 1'b0 || bus.readout_start !== 1'b0
        || bus.busy !== 1'b0 || bus.pll_err !== 1'b0
        || bus.hit_mask !== 8'h00 || bus.event_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset: st=%0d se=%b bz=%b mask=%h cnt=%0d, need zeros",
               bus.state, bus.sample_en, bus.busy, bus.hit_mask,
               bus.event_count);
    end
  endtask

  task automatic test_single_shot();
    setup(2'd0, 8'h04, 8'h00, 6'd3, 1'b0);
    cmd_on(2'd1);
    checks++;
    if (bus.state !== ARMED || bus.sample_en !== 1'b1
        || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_arm: st=%0d se=%b bz=%b, need 1/1/1",
               bus.state, bus.sample_en, bus.busy);
    end
    cmd_off();
    bus.disc_in = 8'h04;
    wait_trig("single");
    bus.disc_in = 8'h00;
    run_event("single", 8'h04, 4, IDLE, 1'b0);
  endtask

  task automatic test_continuous();
    setup(2'd1, 8'h01, 8'h01, 6'd0, 1'b1);
    cmd_on(2'd1);
    cmd_off();
    for (int k = 0; k < 3; k++) begin
      bus.disc_in = 8'h00;
      wait_trig("cont");
      bus.disc_in = 8'h01;
      run_event("cont", 8'h01, 4, ARMED, 1'b0);
    end
    cmd_on(2'd3);
    checks++;
    if (bus.state !== IDLE || bus.sample_en !== 1'b0
        || bus.event_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL cont_stop: st=%0d se=%b cnt=%0d, need 0/0/%0d",
               bus.state, bus.sample_en, bus.event_count, exp_count);
    end
    cmd_off();
  endtask

  task automatic test_forced();
    int tc;
    setup(2'd3, 8'hFF, 8'h00, 6'd0, 1'b0);
    cmd_on(2'd1);
    cmd_off();
    bus.disc_in = 8'hFF;
    tc = 0;
    repeat (10) begin
      tick();
      if (bus.trig_out === 1'b1) tc++;
    end
    bus.readout_done = 1'b1;
    tick();
    bus.readout_done = 1'b0;
    tick();
    checks++;
    if (tc != 0 || bus.state !== ARMED
        || bus.event_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL forced_quiet: trig=%0d st=%0d cnt=%0d, need 0/1/%0d",
               tc, bus.state, bus.event_count, exp_count);
    end
    bus.instruction = 2'd2;
    wait_trig("forced");
    run_event("forced", 8'h00, 1, IDLE, 1'b0);
    bus.disc_in = 8'h00;
    cmd_off();
  endtask

  task automatic test_pll();
    setup(2'd0, 8'h01, 8'h00, 6'd0, 1'b0);
    bus.pll_switch = 1'b1;
    bus.pll_locked = 1'b0;
    cmd_on(2'd1);
    cmd_off();
    checks++;
    if (bus.state !== IDLE || bus.pll_err !== 1'b1) begin
      errors++;
      $display("FAIL pll_reject: st=%0d err=%b, need 0/1",
               bus.state, bus.pll_err);
    end
    bus.pll_locked = 1'b1;
    cmd_on(2'd1);
    cmd_off();
    checks++;
    if (bus.state !== ARMED || bus.pll_err !== 1'b0) begin
      errors++;
      $display("FAIL pll_accept: st=%0d err=%b, need 1/0",
               bus.state, bus.pll_err);
    end
    bus.pll_locked = 1'b0;
    cmd_on(2'd1);
    cmd_off();
    checks++;
    if (bus.state !== ARMED || bus.pll_err !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: st=%0d err=%b, need 1/0",
               bus.state, bus.pll_err);
    end
    bus.pll_locked = 1'b1;
    cmd_on(2'd3);
    cmd_off();
    bus.pll_switch = 1'b0;
  endtask

  task automatic test_stop_readout();
    setup(2'd1, 8'h80, 8'h00, 6'd2, 1'b0);
    cmd_on(2'd1);
    cmd_off();
    bus.disc_in = 8'h81;
    wait_trig("stop_ro");
    bus.disc_in = 8'h00;
    run_event("stop_ro", 8'h80, 3, IDLE, 1'b1);
    repeat (5) tick();
    checks++;
    if (bus.state !== IDLE || bus.trig_out !== 1'b0) begin
      errors++;
      $display("FAIL stop_norearm: st=%0d, need 0", bus.state);
    end
  endtask

  task automatic test_random();
    logic [7:0] pol, msk, dsc, em;
    logic [5:0] td;
    logic sl;
    int kind;
    for (int it = 0; it < 16; it++) begin
      pol = 8'($urandom);
      msk = 8'($urandom) | 8'h01;
      td = 6'($urandom_range(0, 63));
      sl = 1'($urandom);
      kind = $urandom_range(0, 2);
      setup(2'd0, msk, pol, td, sl);
      cmd_on(2'd1);
      cmd_off();
      dsc = 8'($urandom);
      if (((dsc ^ pol) & msk) == 8'h00) dsc = dsc ^ 8'h01;
      em = (kind == 1) ? 8'h00 : ((dsc ^ pol) & msk);
      if (kind == 0) begin
        bus.disc_in = dsc;
      end else if (kind == 1) begin
        bus.instruction = 2'd2;
      end else begin
        bus.instruction = 2'd2;
        repeat (2) tick();
        bus.disc_in = dsc;
      end
      wait_trig("rand");
      bus.disc_in = pol;
      run_event("rand", em, (int'(td) + 1) * (sl ? 4 : 1), IDLE, 1'b0);
      cmd_off();
    end
  endtask

  task automatic test_reset_mid_delay();
    int rs;
    int nb;
    setup(2'd0, 8'h02, 8'h00, 6'd63, 1'b1);
    cmd_on(2'd1);
    cmd_off();
    bus.disc_in = 8'h02;
    wait_trig("rst_mid");
    bus.disc_in = 8'h00;
    repeat (5) tick();
    checks++;
    if (bus.state !== DELAY) begin
      errors++;
      $display("FAIL rst_mid_pre: st=%0d, need 2", bus.state);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
    checks++;
    if (bus.state !== IDLE || bus.sample_en !== 1'b0
        || bus.trig_out !== 1'b0 || bus.readout_start !== 1'b0
        || bus.busy !== 1'b0 || bus.pll_err !== 1'b0
        || bus.hit_mask !== 8'h00 || bus.event_count !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid: st=%0d se=%b mask=%h cnt=%0d, need zeros",
               bus.state, bus.sample_en, bus.hit_mask, bus.event_count);
    end
    rs = 0;
    nb = 0;
    repeat (300) begin
      tick();
      if (bus.readout_start === 1'b1) rs++;
      if (bus.state !== IDLE) nb++;
    end
    checks++;
    if (rs != 0 || nb != 0) begin
      errors++;
      $display("FAIL rst_mid_after: rs=%0d active=%0d, need 0/0", rs, nb);
    end
  endtask

  initial begin
    bus.instruction = 2'd0;
    bus.readout_done = 1'b0;
    bus.pll_switch = 1'b0;
    bus.pll_locked = 1'b0;
    setup(2'd0, 8'h00, 8'h00, 6'd0, 1'b0);
    test_reset();
    test_single_shot();
    test_continuous();
    test_forced();
    test_pll();
    test_stop_readout();
    test_random();
    test_reset_mid_delay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
